// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer controller: FSM state encoding
// and the request validation / strobe-phase helpers.
package bus_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LATCH = 3'd2,
        ST_TURN  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // True when an index addresses an existing register.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return (idx < n);
    endfunction

    // A request is legal when the destination exists and, for
    // register-to-register moves, the source exists and differs from it.
    function automatic logic request_ok(input int unsigned src,
                                        input int unsigned dst,
                                        input logic        imm_en,
                                        input int unsigned n);
        logic ok;
        ok = idx_in_range(dst, n);
        if (!imm_en) begin
            ok = ok && idx_in_range(src, n) && (src != dst);
        end else begin
            ok = ok && 1'b1;
        end
        return ok;
    endfunction

    // Phases in which a source drives the bus (oe or immediate).
    function automatic logic phase_drives(input state_t s);
        return (s == ST_DRIVE) || (s == ST_LATCH);
    endfunction

    // Phase in which the destination strobe is raised.
    function automatic logic phase_latches(input state_t s);
        return (s == ST_LATCH);
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder; all zeros when disabled or index out of range.
module onehot_decoder #(
    parameter int n     = 8,
    parameter int idx_w = 3
) (
    input  logic [idx_w-1:0] idx,
    input  logic             en,
    output logic [n-1:0]     onehot
);

    // Decode the index, suppressing out-of-range values.
    always_comb begin
        onehot = {n{1'b0}};
        if (en && (int'(idx) < n)) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = {n{1'b0}};
        end
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Bus master for the shared tristate register bus. Accepts one transfer at
// a time and sequences DRIVE -> LATCH -> TURN so a single source drives the
// bus while the destination captures it, with a turnaround before the next
// transfer. Illegal requests are answered with a one-cycle err pulse.
module bus_transfer_controller
    import bus_ctrl_pkg::*;
#(
    parameter  int data_bus_size = 32,
    parameter  int num_regs      = 8,
    localparam int idx_w         = $clog2(num_regs)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [idx_w-1:0]         req_src,
    input  logic [idx_w-1:0]         req_dst,
    input  logic                     req_imm_en,
    input  logic [data_bus_size-1:0] req_imm,
    output logic [num_regs-1:0]      oe,
    output logic [num_regs-1:0]      latch,
    inout  wire  [data_bus_size-1:0] data_bus,
    output logic [data_bus_size-1:0] xfer_data,
    output logic                     done,
    output logic                     err,
    output logic                     busy
);

    state_t                   state_r;
    logic [idx_w-1:0]         src_r;
    logic [idx_w-1:0]         dst_r;
    logic                     imm_en_r;
    logic [data_bus_size-1:0] imm_r;
    logic                     imm_drive_r;
    logic [num_regs-1:0]      oe_r;
    logic [num_regs-1:0]      latch_r;
    logic [data_bus_size-1:0] xfer_data_r;
    logic                     done_r;
    logic                     err_r;
    logic                     busy_r;
    logic                     ready_r;

    logic                     accept_s;
    logic                     req_ok_s;
    state_t                   next_state_s;
    logic                     next_imm_en_s;
    logic [idx_w-1:0]         oe_idx_s;
    logic [idx_w-1:0]         latch_idx_s;
    logic                     oe_en_s;
    logic                     latch_en_s;
    logic [num_regs-1:0]      oe_dec_s;
    logic [num_regs-1:0]      latch_dec_s;

    // Work out the phase entered on the next edge so the strobes can be
    // registered and appear together with the state they belong to.
    always_comb begin
        accept_s      = req_valid && ready_r;
        req_ok_s      = request_ok(32'(req_src), 32'(req_dst), req_imm_en, 32'(num_regs));
        next_state_s  = state_r;
        next_imm_en_s = imm_en_r;
        oe_idx_s      = src_r;
        latch_idx_s   = dst_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s  = req_ok_s ? ST_DRIVE : ST_ERR;
                    next_imm_en_s = req_imm_en;
                    oe_idx_s      = req_src;
                    latch_idx_s   = req_dst;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE: next_state_s = ST_LATCH;
            ST_LATCH: next_state_s = ST_TURN;
            ST_TURN:  next_state_s = ST_IDLE;
            ST_ERR:   next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
        oe_en_s    = phase_drives(next_state_s) && !next_imm_en_s;
        latch_en_s = phase_latches(next_state_s);
    end

    onehot_decoder #(.n(num_regs), .idx_w(idx_w)) u_oe_dec (
        .idx    (oe_idx_s),
        .en     (oe_en_s),
        .onehot (oe_dec_s)
    );

    onehot_decoder #(.n(num_regs), .idx_w(idx_w)) u_latch_dec (
        .idx    (latch_idx_s),
        .en     (latch_en_s),
        .onehot (latch_dec_s)
    );

    // Transfer sequencer: state, captured request and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            src_r       <= {idx_w{1'b0}};
            dst_r       <= {idx_w{1'b0}};
            imm_en_r    <= 1'b0;
            imm_r       <= {data_bus_size{1'b0}};
            imm_drive_r <= 1'b0;
            oe_r        <= {num_regs{1'b0}};
            latch_r     <= {num_regs{1'b0}};
            xfer_data_r <= {data_bus_size{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            oe_r        <= oe_dec_s;
            latch_r     <= latch_dec_s;
            imm_drive_r <= phase_drives(next_state_s) && next_imm_en_s;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        src_r    <= req_src;
                        dst_r    <= req_dst;
                        imm_en_r <= req_imm_en;
                        imm_r    <= req_imm;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        err_r    <= !req_ok_s;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    busy_r <= 1'b1;
                end
                ST_LATCH: begin
                    // Destination captures on this same edge.
                    xfer_data_r <= data_bus;
                    done_r      <= 1'b1;
                end
                ST_TURN, ST_ERR: begin
                    imm_en_r <= 1'b0;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    imm_en_r <= 1'b0;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign data_bus  = imm_drive_r ? imm_r : {data_bus_size{1'bz}};
    assign oe        = oe_r;
    assign latch     = latch_r;
    assign xfer_data = xfer_data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign busy      = busy_r;
    assign req_ready = ready_r;

endmodule
